// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants and types for the 7-segment scan decoder.
//   - Segment codes for digits 0..9, ordered a..g (MSB = a).
//   - Active-low one-hot digit enables and the blank pattern.
//   - Digit index type, frame FSM state type, and seg_to_bcd() lookup.
package seg7_pkg;

    localparam logic [6:0] SEG_0 = 7'b1111110;
    localparam logic [6:0] SEG_1 = 7'b0110000;
    localparam logic [6:0] SEG_2 = 7'b1101101;
    localparam logic [6:0] SEG_3 = 7'b1111001;
    localparam logic [6:0] SEG_4 = 7'b0110011;
    localparam logic [6:0] SEG_5 = 7'b1011011;
    localparam logic [6:0] SEG_6 = 7'b1011111;
    localparam logic [6:0] SEG_7 = 7'b1110000;
    localparam logic [6:0] SEG_8 = 7'b1111111;
    localparam logic [6:0] SEG_9 = 7'b1111011;

    localparam logic [3:0] CTRL_UNITS     = 4'b0111;
    localparam logic [3:0] CTRL_TENS      = 4'b1011;
    localparam logic [3:0] CTRL_HUNDREDS  = 4'b1101;
    localparam logic [3:0] CTRL_THOUSANDS = 4'b1110;
    localparam logic [3:0] CTRL_BLANK     = 4'b1111;

    typedef logic [1:0] digit_idx_t;

    // Encoding matches the expected digit index while collecting.
    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StCollect1 = 2'd1,
        StCollect2 = 2'd2,
        StCollect3 = 2'd3
    } frame_state_e;

    // Returns {hit, bcd}; hit = 0 for any unrecognised pattern.
    function automatic logic [4:0] seg_to_bcd(input logic [6:0] seg);
        logic [4:0] r;
        r = 5'b0_0000;
        case (seg)
            SEG_0:   r = {1'b1, 4'd0};
            SEG_1:   r = {1'b1, 4'd1};
            SEG_2:   r = {1'b1, 4'd2};
            SEG_3:   r = {1'b1, 4'd3};
            SEG_4:   r = {1'b1, 4'd4};
            SEG_5:   r = {1'b1, 4'd5};
            SEG_6:   r = {1'b1, 4'd6};
            SEG_7:   r = {1'b1, 4'd7};
            SEG_8:   r = {1'b1, 4'd8};
            SEG_9:   r = {1'b1, 4'd9};
            default: r = 5'b0_0000;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/seg_input_filter.sv
// seg_input_filter: 2-flop synchronizer plus settle filter for the scan bus.
//   clk, reset    : clock, async active-high reset
//   ctrl_in       : raw active-low digit enables
//   segment_in    : raw segment bus (a..g, dp)
//   ctrl_sync     : synchronized digit enables
//   segment_sync  : synchronized segment bus
//   accept        : one-cycle pulse once {ctrl,segment} has been stable long enough
module seg_input_filter #(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] ctrl_in,
    input  logic [7:0] segment_in,
    output logic [3:0] ctrl_sync,
    output logic [7:0] segment_sync,
    output logic       accept
);

    localparam int unsigned CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(SETTLE_CYCLES - 1);

    logic [3:0]    ctrl_meta;
    logic [7:0]    seg_meta;
    logic [11:0]   prev;
    logic [CW-1:0] cnt;
    logic          armed;
    logic          same;

    assign same   = ({ctrl_sync, segment_sync} == prev);
    // armed ensures one accept per settled value, however long it is held.
    assign accept = same && armed && (cnt == CNT_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_meta    <= 4'hF;
            ctrl_sync    <= 4'hF;
            seg_meta     <= 8'h00;
            segment_sync <= 8'h00;
            prev         <= {4'hF, 8'h00};
            cnt          <= '0;
            armed        <= 1'b0;
        end else begin
            ctrl_meta    <= ctrl_in;
            ctrl_sync    <= ctrl_meta;
            seg_meta     <= segment_in;
            segment_sync <= seg_meta;
            prev         <= {ctrl_sync, segment_sync};
            if (!same) begin
                cnt   <= '0;
                armed <= 1'b1;
            end else begin
                if (cnt != CNT_MAX) begin
                    cnt <= cnt + 1'b1;
                end
                if (accept) begin
                    armed <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: decodes a 4-digit multiplexed 7-segment scan back to BCD.
//   clk, reset    : clock, async active-high reset
//   ctrl_in       : active-low one-hot digit enables (1111 = blank)
//   segment_in    : segments a..g on [7:1], dp on [0]
//   digits_out    : {thousands,hundreds,tens,units} of the last good frame
//   dp_out        : decimal points in the same order
//   digits_valid  : digits_out holds a good frame and the display is not stale
//   frame_valid   : one-cycle pulse when digits_out updates
//   err_seg/err_ctrl/err_seq : one-cycle error pulses
//   stale         : no accepted sample for TIMEOUT_CYCLES
module seg_scan_decoder
    import seg7_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 32768,
    parameter int unsigned TO_W           = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  ctrl_in,
    input  logic [7:0]  segment_in,
    output logic [15:0] digits_out,
    output logic [3:0]  dp_out,
    output logic        digits_valid,
    output logic        frame_valid,
    output logic        err_seg,
    output logic        err_ctrl,
    output logic        err_seq,
    output logic        stale
);

    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES);

    logic [3:0]  ctrl_sync;
    logic [7:0]  seg_sync;
    logic        accept;

    seg_input_filter #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_filter (
        .clk         (clk),
        .reset       (reset),
        .ctrl_in     (ctrl_in),
        .segment_in  (segment_in),
        .ctrl_sync   (ctrl_sync),
        .segment_sync(seg_sync),
        .accept      (accept)
    );

    logic [4:0]   dec;
    logic         seg_hit;
    logic [3:0]   seg_bcd;
    logic         seg_dp;
    logic         ctrl_blank;
    logic         ctrl_onehot;
    digit_idx_t   idx;
    digit_idx_t   exp_idx;

    assign dec     = seg_to_bcd(seg_sync[7:1]);
    assign seg_hit = dec[4];
    assign seg_bcd = dec[3:0];
    assign seg_dp  = seg_sync[0];

    always_comb begin
        ctrl_blank  = 1'b0;
        ctrl_onehot = 1'b1;
        idx         = 2'd0;
        case (ctrl_sync)
            CTRL_UNITS:     idx = 2'd0;
            CTRL_TENS:      idx = 2'd1;
            CTRL_HUNDREDS:  idx = 2'd2;
            CTRL_THOUSANDS: idx = 2'd3;
            CTRL_BLANK: begin
                ctrl_blank  = 1'b1;
                ctrl_onehot = 1'b0;
            end
            default:        ctrl_onehot = 1'b0;
        endcase
    end

    frame_state_e    state_q, state_d;
    logic [11:0]     shadow_q, shadow_d;
    logic [2:0]      shadow_dp_q, shadow_dp_d;
    logic            bad_q, bad_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic [15:0]     digits_d;
    logic [3:0]      dp_d;
    logic            digits_valid_d, frame_valid_d, stale_d;
    logic            err_seg_d, err_ctrl_d, err_seq_d;
    logic            timeout_hit;
    logic            store;

    assign exp_idx     = digit_idx_t'(state_q);
    // Fires on the cycle the counter would step onto TIMEOUT_CYCLES; an accept wins.
    assign timeout_hit = !accept && (to_cnt_q == TO_MAX - 1'b1);

    always_comb begin
        state_d        = state_q;
        shadow_d       = shadow_q;
        shadow_dp_d    = shadow_dp_q;
        bad_d          = bad_q;
        to_cnt_d       = to_cnt_q;
        digits_d       = digits_out;
        dp_d           = dp_out;
        digits_valid_d = digits_valid;
        frame_valid_d  = 1'b0;
        stale_d        = stale;
        err_seg_d      = 1'b0;
        err_ctrl_d     = 1'b0;
        err_seq_d      = 1'b0;
        store          = 1'b0;

        if (accept) begin
            to_cnt_d = '0;
            stale_d  = 1'b0;
        end else if (to_cnt_q != TO_MAX) begin
            to_cnt_d = to_cnt_q + 1'b1;
        end

        if (timeout_hit) begin
            stale_d        = 1'b1;
            digits_valid_d = 1'b0;
            state_d        = StIdle;
        end

        if (accept && !ctrl_blank && !ctrl_onehot) begin
            err_ctrl_d = 1'b1;
            state_d    = StIdle;
        end

        if (accept && ctrl_onehot) begin
            err_seg_d = !seg_hit;
            if (idx == 2'd0) begin
                // Units always (re)starts a frame, from any state.
                store   = 1'b1;
                bad_d   = !seg_hit;
                state_d = StCollect1;
            end else if (state_q != StIdle) begin
                if (idx == exp_idx) begin
                    if (idx == 2'd3) begin
                        if (!bad_q && seg_hit) begin
                            digits_d       = {seg_bcd, shadow_q};
                            dp_d           = {seg_dp, shadow_dp_q};
                            frame_valid_d  = 1'b1;
                            digits_valid_d = 1'b1;
                        end
                        state_d = StIdle;
                    end else begin
                        store   = 1'b1;
                        bad_d   = bad_q | !seg_hit;
                        state_d = frame_state_e'(exp_idx + 2'd1);
                    end
                end else if (idx == exp_idx - 2'd1) begin
                    // Same digit re-accepted after a mid-display segment change.
                    store = 1'b1;
                    bad_d = bad_q | !seg_hit;
                end else begin
                    err_seq_d = 1'b1;
                    state_d   = StIdle;
                end
            end
        end

        if (store) begin
            case (idx)
                2'd0: begin
                    shadow_d[3:0]  = seg_bcd;
                    shadow_dp_d[0] = seg_dp;
                end
                2'd1: begin
                    shadow_d[7:4]  = seg_bcd;
                    shadow_dp_d[1] = seg_dp;
                end
                default: begin
                    shadow_d[11:8] = seg_bcd;
                    shadow_dp_d[2] = seg_dp;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            shadow_q     <= '0;
            shadow_dp_q  <= '0;
            bad_q        <= 1'b0;
            to_cnt_q     <= '0;
            digits_out   <= '0;
            dp_out       <= '0;
            digits_valid <= 1'b0;
            frame_valid  <= 1'b0;
            stale        <= 1'b0;
            err_seg      <= 1'b0;
            err_ctrl     <= 1'b0;
            err_seq      <= 1'b0;
        end else begin
            state_q      <= state_d;
            shadow_q     <= shadow_d;
            shadow_dp_q  <= shadow_dp_d;
            bad_q        <= bad_d;
            to_cnt_q     <= to_cnt_d;
            digits_out   <= digits_d;
            dp_out       <= dp_d;
            digits_valid <= digits_valid_d;
            frame_valid  <= frame_valid_d;
            stale        <= stale_d;
            err_seg      <= err_seg_d;
            err_ctrl     <= err_ctrl_d;
            err_seq      <= err_seq_d;
        end
    end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Scoreboard bench for seg_scan_decoder: stimulus queues expected frames,
// a negedge monitor pops and compares on every frame_valid pulse.
module tb_seg_scan_decoder;

    localparam int TIMEOUT = 32768;
    localparam int LAT     = 7;   // pins -> frame_valid: 2 sync + 4 settle + 1

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  ctrl_in;
    logic [7:0]  segment_in;
    logic [15:0] digits_out;
    logic [3:0]  dp_out;
    logic        digits_valid, frame_valid, err_seg, err_ctrl, err_seq, stale;

    seg_scan_decoder dut (
        .clk         (clk),
        .reset       (reset),
        .ctrl_in     (ctrl_in),
        .segment_in  (segment_in),
        .digits_out  (digits_out),
        .dp_out      (dp_out),
        .digits_valid(digits_valid),
        .frame_valid (frame_valid),
        .err_seg     (err_seg),
        .err_ctrl    (err_ctrl),
        .err_seq     (err_seq),
        .stale       (stale)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] digits;
        logic [3:0]  dp;
        int          at;
    } frame_t;

    frame_t exp_q[$];
    int checks = 0, errors = 0;
    int n_frames = 0, n_seg = 0, n_ctrl = 0, n_seq = 0;
    int s_frames, s_seg, s_ctrl, s_seq;

    logic [7:0] seg_code [10];
    initial begin
        seg_code[0] = 8'b1111_1100; seg_code[1] = 8'b0110_0000;
        seg_code[2] = 8'b1101_1010; seg_code[3] = 8'b1111_0010;
        seg_code[4] = 8'b0110_0110; seg_code[5] = 8'b1011_0110;
        seg_code[6] = 8'b1011_1110; seg_code[7] = 8'b1110_0000;
        seg_code[8] = 8'b1111_1110; seg_code[9] = 8'b1111_0110;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Monitor: error pulse counting and frame scoreboard.
    always @(negedge clk) begin
        if (!reset) begin
            if (err_seg)  n_seg++;
            if (err_ctrl) n_ctrl++;
            if (err_seq)  n_seq++;
            if (frame_valid) begin
                frame_t f;
                n_frames++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame: got digits %h, required no frame", digits_out);
                end else begin
                    f = exp_q.pop_front();
                    check("frame_digits", 32'(digits_out), 32'(f.digits));
                    check("frame_dp", 32'(dp_out), 32'(f.dp));
                    check("frame_cycle", cyc, f.at);
                    check("frame_digits_valid", 32'(digits_valid), 32'd1);
                end
            end
        end
    end

    task automatic drive(input logic [3:0] c, input logic [7:0] s, input int hold);
        ctrl_in    = c;
        segment_in = s;
        repeat (hold) @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] ctrl_of(input int i);
        case (i)
            0:       return 4'b0111;
            1:       return 4'b1011;
            2:       return 4'b1101;
            default: return 4'b1110;
        endcase
    endfunction

    task automatic digit(input int i, input int v, input logic dp, input int hold);
        drive(ctrl_of(i), seg_code[v] | {7'b0, dp}, hold);
    endtask

    task automatic push_frame(input logic [15:0] w, input logic [3:0] dp);
        frame_t f;
        f.digits = w;
        f.dp     = dp;
        f.at     = cyc + LAT;
        exp_q.push_back(f);
    endtask

    task automatic scan(input logic [15:0] w, input logic [3:0] dp);
        digit(0, int'(w[3:0]), dp[0], 20);
        digit(1, int'(w[7:4]), dp[1], 20);
        digit(2, int'(w[11:8]), dp[2], 20);
        push_frame(w, dp);
        digit(3, int'(w[15:12]), dp[3], 20);
        drive(4'hF, 8'h00, 10);
    endtask

    task automatic snap();
        s_frames = n_frames; s_seg = n_seg; s_ctrl = n_ctrl; s_seq = n_seq;
    endtask

    task automatic check_deltas(input string t, input int fr, input int sg, input int ct, input int sq);
        check({t, "_frames"}, n_frames - s_frames, fr);
        check({t, "_err_seg"}, n_seg - s_seg, sg);
        check({t, "_err_ctrl"}, n_ctrl - s_ctrl, ct);
        check({t, "_err_seq"}, n_seq - s_seq, sq);
    endtask

    initial begin
        reset      = 1'b1;
        ctrl_in    = 4'hF;
        segment_in = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_digits", 32'(digits_out), 0);
        check("rst_dp", 32'(dp_out), 0);
        check("rst_flags", {26'b0, digits_valid, frame_valid, err_seg, err_ctrl, err_seq, stale}, 0);
        reset = 1'b0;
        drive(4'hF, 8'h00, 5);

        // 1: clean scan of 1234
        snap();
        scan(16'h1234, 4'b0000);
        check("t1_digits", 32'(digits_out), 32'h1234);
        check("t1_valid", 32'(digits_valid), 1);
        check_deltas("t1", 1, 0, 0, 0);

        // 2: 2-cycle glitch during the units slot
        snap();
        digit(0, 4, 1'b0, 8);
        drive(4'b0111, 8'b1011_0110, 2);
        digit(0, 4, 1'b0, 10);
        digit(1, 3, 1'b0, 20);
        digit(2, 2, 1'b0, 20);
        push_frame(16'h1234, 4'b0000);
        digit(3, 1, 1'b0, 20);
        drive(4'hF, 8'h00, 10);
        check("t2_digits", 32'(digits_out), 32'h1234);
        check_deltas("t2", 1, 0, 0, 0);

        // 3: bad hundreds segment, then a clean 5678
        snap();
        digit(0, 4, 1'b0, 20);
        digit(1, 3, 1'b0, 20);
        drive(4'b1101, 8'b0000_0010, 20);
        digit(3, 1, 1'b0, 20);
        drive(4'hF, 8'h00, 10);
        check("t3_digits_held", 32'(digits_out), 32'h1234);
        check_deltas("t3a", 0, 1, 0, 0);
        snap();
        scan(16'h5678, 4'b0000);
        check("t3_digits", 32'(digits_out), 32'h5678);
        check_deltas("t3b", 1, 0, 0, 0);

        // 4: units then hundreds, then an illegal ctrl pattern
        snap();
        digit(0, 1, 1'b0, 20);
        digit(2, 3, 1'b0, 20);
        drive(4'b0011, seg_code[0], 20);
        drive(4'hF, 8'h00, 10);
        check("t4_digits", 32'(digits_out), 32'h5678);
        check("t4_stale", 32'(stale), 0);
        check_deltas("t4", 0, 0, 1, 1);

        // 5: timeout; the blank from test 4 was accepted ~4 cycles ago
        drive(4'hF, 8'h00, TIMEOUT - 100);
        check("t5_not_yet_stale", 32'(stale), 0);
        check("t5_valid_before", 32'(digits_valid), 1);
        drive(4'hF, 8'h00, 200);
        check("t5_stale", 32'(stale), 1);
        check("t5_valid_dropped", 32'(digits_valid), 0);
        check("t5_digits_held", 32'(digits_out), 32'h5678);
        snap();
        digit(0, 1, 1'b0, 20);
        check("t5_stale_cleared", 32'(stale), 0);
        check("t5_valid_still_low", 32'(digits_valid), 0);
        digit(1, 2, 1'b0, 20);
        digit(2, 3, 1'b0, 20);
        push_frame(16'h4321, 4'b0000);
        digit(3, 4, 1'b0, 20);
        drive(4'hF, 8'h00, 10);
        check("t5_digits", 32'(digits_out), 32'h4321);
        check("t5_valid_back", 32'(digits_valid), 1);
        check_deltas("t5", 1, 0, 0, 0);

        // 6: reset mid-frame, then 9999 with a hundreds decimal point
        digit(0, 9, 1'b0, 20);
        digit(1, 9, 1'b0, 20);
        reset = 1'b1;
        #1;
        check("t6_rst_digits", 32'(digits_out), 0);
        check("t6_rst_flags", {28'b0, digits_valid, frame_valid, stale, err_seq}, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        drive(4'hF, 8'h00, 10);
        snap();
        scan(16'h9999, 4'b0100);
        check("t6_digits", 32'(digits_out), 32'h9999);
        check("t6_dp", 32'(dp_out), 32'h4);
        check("t6_valid", 32'(digits_valid), 1);
        check_deltas("t6", 1, 0, 0, 0);

        drive(4'hF, 8'h00, 20);
        check("frames_pending", exp_q.size(), 0);
        check("frames_total", n_frames, 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
